// File: rtl/flit_ejector.sv
// Ejection-port sink: per-VC head/tail framing check, destination check, flit/packet
// counters and delayed credit return. Optional latency statistics under EJECT_LATENCY_EN.
module flit_ejector #(
    parameter int MAXVC    = 4,
    parameter int VC_BITS  = 2,
    parameter int DST_BITS = 4,
    parameter int MY_ID    = 0,
    parameter int CDLY_MAX = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_load,
    input  logic [$clog2(CDLY_MAX)-1:0] cfg_credit_delay,
    input  logic                        in_valid,
    input  logic [VC_BITS-1:0]          in_vc,
    input  logic                        in_head,
    input  logic                        in_tail,
    input  logic [DST_BITS-1:0]         in_dst,
`ifdef EJECT_LATENCY_EN
    input  logic [15:0]                 in_ts,
    input  logic [15:0]                 cycle,
    output logic [31:0]                 lat_sum,
    output logic [15:0]                 lat_max,
`endif
    output logic                        cr_valid,
    output logic [VC_BITS-1:0]          cr_vc,
    output logic [CNT_BITS-1:0]         flit_cnt,
    output logic [CNT_BITS-1:0]         pkt_cnt,
    output logic                        err,
    output logic [1:0]                  err_code
);
    localparam int CDW = $clog2(CDLY_MAX);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    logic [0:0]          st_q [MAXVC];
    logic [0:0]          st_d [MAXVC];
    logic                dl_v_q  [CDLY_MAX-1];
    logic                dl_v_d  [CDLY_MAX-1];
    logic [VC_BITS-1:0]  dl_vc_q [CDLY_MAX-1];
    logic [VC_BITS-1:0]  dl_vc_d [CDLY_MAX-1];
    logic [CDW-1:0]      dly_q, dly_d;
    logic                cr_valid_q, cr_valid_d;
    logic [VC_BITS-1:0]  cr_vc_q, cr_vc_d;
    logic [CNT_BITS-1:0] flit_cnt_q, flit_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic                accept, sel_open, pkt_done, tap_v;
    logic [VC_BITS-1:0]  tap_vc;
    logic [1:0]          flit_code;

    // A flit arriving in the same cycle as cfg_load is discarded entirely.
    assign accept   = in_valid & ~cfg_load;
    assign sel_open = (st_q[in_vc] == ST_OPEN);
    assign pkt_done = in_tail & (in_head | sel_open);

    always_comb begin
        flit_code = 2'b00;
        if (in_dst != DST_BITS'(MY_ID))  flit_code = 2'b11;
        else if (sel_open && in_head)    flit_code = 2'b10;
        else if (!sel_open && !in_head)  flit_code = 2'b01;
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAXVC; gi++) begin : g_vc
            always_comb begin
                st_d[gi] = st_q[gi];
                if (cfg_load)
                    st_d[gi] = ST_IDLE;
                else if (in_valid && in_vc == VC_BITS'(gi))
                    st_d[gi] = (in_head ? ~in_tail : (st_q[gi] == ST_OPEN) & ~in_tail) ? ST_OPEN : ST_IDLE;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) st_q[gi] <= ST_IDLE;
                else        st_q[gi] <= st_d[gi];
            end
        end

        // Stage i holds credits accepted i+1 cycles ago; the output register adds one more.
        for (gi = 0; gi < CDLY_MAX - 1; gi++) begin : g_dl
            always_comb begin
                if (gi == 0) begin
                    dl_v_d[gi]  = accept;
                    dl_vc_d[gi] = in_vc;
                end else begin
                    dl_v_d[gi]  = dl_v_q[(gi == 0) ? 0 : gi - 1] & ~cfg_load;
                    dl_vc_d[gi] = dl_vc_q[(gi == 0) ? 0 : gi - 1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_v_q[gi]  <= 1'b0;
                    dl_vc_q[gi] <= '0;
                end else begin
                    dl_v_q[gi]  <= dl_v_d[gi];
                    dl_vc_q[gi] <= dl_vc_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        tap_v  = accept;
        tap_vc = in_vc;
        for (int i = 1; i < CDLY_MAX; i++) begin
            if (int'(dly_q) == i) begin
                tap_v  = dl_v_q[i-1];
                tap_vc = dl_vc_q[i-1];
            end
        end
    end

    always_comb begin
        cr_valid_d = tap_v & ~cfg_load;
        cr_vc_d    = cr_valid_d ? tap_vc : '0;
        dly_d      = dly_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (cfg_load) begin
            dly_d      = (cfg_credit_delay > CDW'(CDLY_MAX - 1)) ? CDW'(CDLY_MAX - 1) : cfg_credit_delay;
            flit_cnt_d = '0;
            pkt_cnt_d  = '0;
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end else if (in_valid) begin
            if (flit_cnt_q != '1)           flit_cnt_d = flit_cnt_q + 1'b1;
            if (pkt_done && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
            if (!err_q && flit_code != 2'b00) begin
                err_d      = 1'b1;
                err_code_d = flit_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q      <= '0;
            cr_valid_q <= 1'b0;
            cr_vc_q    <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            dly_q      <= dly_d;
            cr_valid_q <= cr_valid_d;
            cr_vc_q    <= cr_vc_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cr_valid = cr_valid_q;
    assign cr_vc    = cr_vc_q;
    assign flit_cnt = flit_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err      = err_q;
    assign err_code = err_code_q;

`ifdef EJECT_LATENCY_EN
    logic [31:0] lat_sum_q, lat_sum_d;
    logic [15:0] lat_max_q, lat_max_d, lat;
    logic [32:0] sum_w;

    always_comb begin
        lat       = cycle - in_ts;
        sum_w     = {1'b0, lat_sum_q} + {17'd0, lat};
        lat_sum_d = lat_sum_q;
        lat_max_d = lat_max_q;
        if (cfg_load) begin
            lat_sum_d = '0;
            lat_max_d = '0;
        end else if (accept && in_head) begin
            lat_sum_d = sum_w[32] ? '1 : sum_w[31:0];
            if (lat > lat_max_q) lat_max_d = lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else begin
            lat_sum_q <= lat_sum_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign lat_sum = lat_sum_q;
    assign lat_max = lat_max_q;
`endif
endmodule

// File: tb/tb_flit_ejector.sv
// Bench for flit_ejector: framing table, directed credit/reset sequences and
// randomized traffic checked against a queue-based credit schedule model.
module tb_flit_ejector;
    localparam int MAXVC = 4;
    localparam int MY_ID = 0;

    logic        clk = 1'b0;
    logic        rst_n, cfg_load, in_valid, in_head, in_tail;
    logic [2:0]  cfg_credit_delay;
    logic [1:0]  in_vc;
    logic [3:0]  in_dst;
    logic        cr_valid, err;
    logic [1:0]  cr_vc, err_code;
    logic [15:0] flit_cnt, pkt_cnt;
`ifdef EJECT_LATENCY_EN
    logic [15:0] in_ts, cycle_s, lat_max;
    logic [31:0] lat_sum;
`endif

    always #5 clk = ~clk;

    flit_ejector dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_credit_delay(cfg_credit_delay),
        .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail), .in_dst(in_dst),
`ifdef EJECT_LATENCY_EN
        .in_ts(in_ts), .cycle(cycle_s), .lat_sum(lat_sum), .lat_max(lat_max),
`endif
        .cr_valid(cr_valid), .cr_vc(cr_vc), .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt),
        .err(err), .err_code(err_code)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: each accepted flit schedules one credit at an absolute cycle.
    typedef struct { int due; int vc; } cr_t;
    cr_t  crq[$];
    int   m_flit, m_pkt, m_d;
    bit   m_err;
    int   m_code;
    bit   m_open [MAXVC];

    typedef struct {
        logic [1:0] vc; logic h; logic t; logic [3:0] dst;
        int flit; int pkt; int e; int code;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_flit = 0; m_pkt = 0; m_err = 0; m_code = 0;
        for (int i = 0; i < MAXVC; i++) m_open[i] = 0;
        crq.delete();
    endfunction

    function automatic void model_edge();
        int c;
        if (cfg_load) begin
            model_clear();
            m_d = (int'(cfg_credit_delay) > 7) ? 7 : int'(cfg_credit_delay);
        end else if (in_valid) begin
            if (int'(in_dst) != MY_ID)          c = 3;
            else if (m_open[in_vc] && in_head)  c = 2;
            else if (!m_open[in_vc] && !in_head) c = 1;
            else                                c = 0;
            if (c != 0 && !m_err) begin m_err = 1; m_code = c; end
            if (m_flit < 65535) m_flit++;
            if (in_tail && (in_head || m_open[in_vc]) && m_pkt < 65535) m_pkt++;
            if (in_head)      m_open[in_vc] = !in_tail;
            else if (in_tail) m_open[in_vc] = 0;
            crq.push_back('{cyc + 1 + m_d, int'(in_vc)});
        end
    endfunction

    task automatic tick();
        bit exp_v;
        if (rst_n) model_edge();
        @(posedge clk); #1;
        cyc++;
        exp_v = (crq.size() > 0) && (crq[0].due == cyc);
        chk("cr_valid", cr_valid, exp_v);
        if (exp_v) begin
            chk("cr_vc", cr_vc, crq[0].vc);
            void'(crq.pop_front());
        end
        chk("flit_cnt", flit_cnt, m_flit);
        chk("pkt_cnt", pkt_cnt, m_pkt);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
    endtask

    task automatic flit(input int vc, input bit h, input bit t, input int dst);
        in_valid = 1; in_vc = vc[1:0]; in_head = h; in_tail = t; in_dst = dst[3:0];
        tick();
        in_valid = 0; in_head = 0; in_tail = 0; in_dst = 4'(MY_ID);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) tick();
    endtask

    task automatic load(input int d);
        cfg_load = 1; cfg_credit_delay = d[2:0];
        tick();
        cfg_load = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cr_valid"}, cr_valid, 0);
        chk({tag, "_cr_vc"}, cr_vc, 0);
        chk({tag, "_flit_cnt"}, flit_cnt, 0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        model_clear();
        m_d = 0;
        check_zero("async_rst");
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; cfg_load = 0; cfg_credit_delay = 0; in_valid = 0;
        in_vc = 0; in_head = 0; in_tail = 0; in_dst = 4'(MY_ID);
`ifdef EJECT_LATENCY_EN
        in_ts = 0; cycle_s = 0;
`endif
        model_clear();
        m_d = 0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1;

        // 3-flit packet on VC1 with D=2: credits three cycles after each flit.
        load(2);
        flit(1, 1, 0, MY_ID);
        flit(1, 0, 0, MY_ID);
        flit(1, 0, 1, MY_ID);
        chk("d2_first_credit", {cr_valid, cr_vc}, {1'b1, 2'd1});
        idle(2);
        chk("d2_last_credit", {cr_valid, cr_vc}, {1'b1, 2'd1});
        idle(1);
        chk("d2_no_extra_credit", cr_valid, 0);
        chk("d2_counts", {flit_cnt, pkt_cnt, 15'd0, err}, {16'd3, 16'd1, 15'd0, 1'b0});

        // Single-flit packet with D=0, then a tail-only flit proves VC0 returned to IDLE.
        load(0);
        flit(0, 1, 1, MY_ID);
        chk("d0_credit", {cr_valid, cr_vc}, {1'b1, 2'd0});
        chk("d0_pkt", pkt_cnt, 1);
        flit(0, 0, 1, MY_ID);
        chk("d0_idle_err", {err, err_code}, {1'b1, 2'b01});
        idle(2);

        // Interleaved 2-flit packets on VC0 and VC2.
        load(1);
        flit(0, 1, 0, MY_ID);
        flit(2, 1, 0, MY_ID);
        flit(0, 0, 1, MY_ID);
        flit(2, 0, 1, MY_ID);
        idle(3);
        chk("ilv_pkt", pkt_cnt, 2);
        chk("ilv_err", err, 0);

        // Body on idle VC3, then a misroute: first error code stays 01.
        load(0);
        flit(3, 0, 0, MY_ID);
        flit(0, 1, 1, MY_ID + 1);
        chk("first_err", {err, err_code}, {1'b1, 2'b01});
        chk("first_err_flits", flit_cnt, 2);
        idle(2);

        // A flit presented together with cfg_load is ignored.
        in_valid = 1; in_vc = 2; in_head = 1; in_tail = 1;
        load(3);
        in_valid = 0; in_head = 0; in_tail = 0;
        idle(5);
        chk("load_drops_flit", flit_cnt, 0);

        // D=5 with pending credits, reset mid-delay: nothing emitted afterwards.
        load(5);
        flit(1, 1, 0, MY_ID);
        flit(1, 0, 1, MY_ID);
        idle(1);
        do_reset();
        idle(10);
        check_zero("post_rst");

        // Framing table, D=0.
        tbl[0] = '{2'd0, 1'b1, 1'b1, 4'd0, 1, 1, 0, 0};
        tbl[1] = '{2'd1, 1'b1, 1'b0, 4'd0, 2, 1, 0, 0};
        tbl[2] = '{2'd1, 1'b0, 1'b0, 4'd0, 3, 1, 0, 0};
        tbl[3] = '{2'd1, 1'b0, 1'b1, 4'd0, 4, 2, 0, 0};
        tbl[4] = '{2'd2, 1'b1, 1'b0, 4'd0, 5, 2, 0, 0};
        tbl[5] = '{2'd2, 1'b1, 1'b1, 4'd0, 6, 3, 1, 2};
        tbl[6] = '{2'd3, 1'b0, 1'b1, 4'd0, 7, 3, 1, 2};
        tbl[7] = '{2'd0, 1'b1, 1'b1, 4'd1, 8, 4, 1, 2};
        load(0);
        for (int i = 0; i < 8; i++) begin
            flit(tbl[i].vc, tbl[i].h, tbl[i].t, tbl[i].dst);
            chk($sformatf("tbl%0d_flit", i), flit_cnt, tbl[i].flit);
            chk($sformatf("tbl%0d_pkt", i), pkt_cnt, tbl[i].pkt);
            chk($sformatf("tbl%0d_err", i), {err, err_code}, {tbl[i].e[0], tbl[i].code[1:0]});
        end
        idle(2);

        // Randomized traffic against the model.
        load($urandom_range(0, 7));
        for (int i = 0; i < 500; i++) begin
            cfg_load         = ($urandom_range(0, 99) < 3);
            cfg_credit_delay = 3'($urandom_range(0, 7));
            in_valid         = ($urandom_range(0, 99) < 70);
            in_vc            = 2'($urandom_range(0, 3));
            in_head          = 1'($urandom_range(0, 1));
            in_tail          = 1'($urandom_range(0, 1));
            in_dst           = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'(MY_ID);
            tick();
        end
        cfg_load = 0;
        idle(10);

`ifdef EJECT_LATENCY_EN
        load(0);
        cycle_s = 16'd100; in_ts = 16'd93;
        flit(0, 1, 1, MY_ID);
        cycle_s = 16'd5; in_ts = 16'hFFF9;
        flit(1, 1, 1, MY_ID);
        chk("lat_sum", lat_sum, 19);
        chk("lat_max", lat_max, 12);
        load(0);
        chk("lat_sum_clr", lat_sum, 0);
        chk("lat_max_clr", lat_max, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
